// File: rtl/irq_timer_pkg.sv
// Shared constants for the machine timer / interrupt controller: register map,
// FSM state encoding and helpers for 32-bit views of the wide counters.
package irq_timer_pkg;

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_PRESCALE = 8'h08;
  localparam logic [7:0] OFF_ENABLE   = 8'h0C;
  localparam logic [7:0] OFF_PENDING  = 8'h10;
  localparam logic [7:0] OFF_CLAIM    = 8'h14;
  localparam int         OFF_CMP_BASE = 32'h20;
  localparam int         CMP_STRIDE   = 8;

  localparam int MAX_TIMERS = 8;
  localparam int MAX_EXT    = 16;
  localparam int MAX_CNT_W  = 64;
  localparam int PRESCALE_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Replace one 32-bit half of a 64-bit value; counters narrower than 64 bits
  // are widened before and truncated after, so bits >= CNT_W are dropped.
  function automatic logic [63:0] set_word(input logic [63:0] cur, input logic hi,
                                           input logic [31:0] d);
    set_word = hi ? {d, cur[31:0]} : {cur[63:32], d};
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] v, input logic hi);
    word_of = hi ? v[63:32] : v[31:0];
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the lowest set bit (lowest index = highest priority).
module irq_prio_enc #(
  parameter  int N  = 6,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/irq_timer_ctrl.sv
// Machine timer with prescaler, compare channels and edge-latched external
// lines, arbitrated into one request/ack/done handshake towards csr_reg.
module irq_timer_ctrl
  import irq_timer_pkg::*;
#(
  parameter  int          NUM_TIMERS = 2,
  parameter  int          NUM_EXT    = 4,
  parameter  int          CNT_W      = 64,
  parameter  logic [31:0] BASE_ADDR  = 32'h0000_F000,
  localparam int          NSRC       = NUM_TIMERS + NUM_EXT,
  localparam int          ID_W       = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int          EXT_W      = (NUM_EXT > 0) ? NUM_EXT : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [31:0]      rdata,
  input  logic [EXT_W-1:0] ext_irq,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             irq_done
);

  localparam int ACT_W = 1 << ID_W;

  logic                  sel, wr;
  logic [7:0]            off;
  logic [CNT_W-1:0]      mtime;
  logic [63:0]           mtime64;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic                  tick_en;
  logic [NSRC-1:0]       enable, pending, active;
  logic [ACT_W-1:0]      active_pad;
  logic [CNT_W-1:0]      cmp [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] timer_pend;
  logic [EXT_W-1:0]      ext_prev, ext_pend, ext_rise, ext_clr;
  logic                  win_any;
  logic [ID_W-1:0]       win_idx;
  irq_state_e            state;

  assign sel     = (addr[31:8] == BASE_ADDR[31:8]);
  assign wr      = wr_en & sel;
  assign off     = addr[7:0];
  assign mtime64 = 64'(mtime);
  assign tick_en = (pcnt == prescale);

  // Prescaler, mtime, enable mask and external edge latches
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      prescale <= '0;
      pcnt     <= '0;
      enable   <= '0;
      ext_prev <= '0;
      ext_pend <= '0;
    end else begin
      if (wr && off == OFF_PRESCALE) begin
        prescale <= wdata[PRESCALE_W-1:0];
        pcnt     <= '0;
      end else if (tick_en) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
      if (wr && off == OFF_MTIME_LO)      mtime <= CNT_W'(set_word(mtime64, 1'b0, wdata));
      else if (wr && off == OFF_MTIME_HI) mtime <= CNT_W'(set_word(mtime64, 1'b1, wdata));
      else if (tick_en)                   mtime <= mtime + CNT_W'(1);
      if (wr && off == OFF_ENABLE) enable <= wdata[NSRC-1:0];
      ext_prev <= ext_irq;
      ext_pend <= (ext_pend & ~ext_clr) | ext_rise;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (rst) begin
        cmp[k] <= '1;
      end else if (wr && off == 8'(OFF_CMP_BASE + CMP_STRIDE * k)) begin
        cmp[k] <= CNT_W'(set_word(64'(cmp[k]), 1'b0, wdata));
      end else if (wr && off == 8'(OFF_CMP_BASE + CMP_STRIDE * k + 4)) begin
        cmp[k] <= CNT_W'(set_word(64'(cmp[k]), 1'b1, wdata));
      end
    end
  end

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
    assign timer_pend[k] = (mtime >= cmp[k]);
  end

  assign ext_rise = ext_irq & ~ext_prev;

  // Ext pending clears come from W1C writes and from acking that source
  always_comb begin
    ext_clr = '0;
    for (int e = 0; e < NUM_EXT; e++) begin
      if (wr && off == OFF_PENDING && wdata[NUM_TIMERS+e]) ext_clr[e] = 1'b1;
      if (state == REQ && irq_ack && irq_id == ID_W'(NUM_TIMERS + e)) ext_clr[e] = 1'b1;
    end
  end

  always_comb begin
    pending = '0;
    pending[NUM_TIMERS-1:0] = timer_pend;
    for (int e = 0; e < NUM_EXT; e++) pending[NUM_TIMERS+e] = ext_pend[e];
  end

  assign active     = pending & enable;
  assign active_pad = ACT_W'(active);

  irq_prio_enc #(.N(NSRC)) u_prio (
    .req (active),
    .any (win_any),
    .idx (win_idx)
  );

  // Request/ack/done handshake: irq_req is high exactly while in REQ and
  // irq_id stays frozen from arbitration until the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_id  <= win_idx;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end else if (!active_pad[irq_id]) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en && sel) begin
      case (off)
        OFF_MTIME_LO: rdata = mtime64[31:0];
        OFF_MTIME_HI: rdata = mtime64[63:32];
        OFF_PRESCALE: rdata = 32'(prescale);
        OFF_ENABLE:   rdata = 32'(enable);
        OFF_PENDING:  rdata = 32'(pending);
        OFF_CLAIM:    rdata = 32'({state, irq_id});
        default:      rdata = '0;
      endcase
      for (int k = 0; k < NUM_TIMERS; k++) begin
        if (off == 8'(OFF_CMP_BASE + CMP_STRIDE * k))     rdata = word_of(64'(cmp[k]), 1'b0);
        if (off == 8'(OFF_CMP_BASE + CMP_STRIDE * k + 4)) rdata = word_of(64'(cmp[k]), 1'b1);
      end
    end
  end

endmodule
